fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction-fetch stage with PC register and IF/ID pipeline register for the 5-stage RISC-V core. It issues one outstanding request to a variable-latency instruction memory and buffers one returned word while decode is stalled. It honours `stall_f`/`stall_d` from the load-use hazard logic and redirects on taken branches and jumps. It feeds decode with `instr_d`, `pc_d` and `valid_d`, and inserts NOP bubbles whenever no instruction is available.

## Interface
- `RESET_PC`, 32'h0000_0000, fetch address after reset
- `clk` in 1: single clock, rising edge
- `rst` in 1: reset, synchronous, active-high
- `stall_f` in 1: hold PC and suppress issuing new requests
- `stall_d` in 1: hold the IF/ID register
- `redirect_valid` in 1: taken branch or jump resolved; has priority over both stalls
- `redirect_pc` in 32: redirect target; bits [1:0] ignored and treated as 0
- `imem_req` out 1: request valid; the request is accepted in the same cycle it is asserted
- `imem_addr` out 32: request word address
- `imem_rvalid` in 1: response valid, at least 1 cycle after the request
- `imem_rdata` in 32: response instruction
- `instr_d` out 32: IF/ID instruction
- `pc_d` out 32: IF/ID PC
- `pc_plus4_d` out 32: `pc_d` + 4
- `valid_d` out 1: IF/ID holds a real instruction

## Operation
- `pc_f` is the address of the oldest instruction not yet delivered to IF/ID.
- There are three FSM states: `F_IDLE`, `F_WAIT`, `F_HOLD`.
- **F_IDLE**
  - `imem_req` = `!stall_f && !redirect_valid`, with `imem_addr` = `pc_f`.
  - If a request is issued, go to `F_WAIT`.
- **F_WAIT**
  - `imem_req` = 0 unless the same-cycle reissue below applies.
  - On `imem_rvalid` with `discard` = 0 and `!stall_d`:
    - load IF/ID with `instr_d` = `imem_rdata`, `pc_d` = `pc_f`, `valid_d` = 1;
    - set `pc_f` += 4;
    - if `!stall_f`, issue the next request in the same cycle (`imem_addr` = `pc_f` + 4) and stay in `F_WAIT`; otherwise go to `F_IDLE`.
  - On `imem_rvalid` with `stall_d`: capture `imem_rdata` and `pc_f` in the skid buffer and go to `F_HOLD`.
  - On `imem_rvalid` with `discard` = 1: drop the response, clear `discard`, go to `F_IDLE`.
- **F_HOLD**
  - `imem_req` = 0.
  - When `!stall_d`: load IF/ID from the buffer, set `pc_f` += 4, go to `F_IDLE`.
- **IF/ID update when nothing is delivered**
  - If `!stall_d` and no instruction is delivered this cycle, IF/ID takes a bubble: `valid_d` = 0, `instr_d` = `NOP_INSTR` (32'h0000_0013), `pc_d` held.
  - If `stall_d`, IF/ID holds all fields.
- **Redirect** (`redirect_valid` = 1) overrides everything:
  - `pc_f` ← `redirect_pc`;
  - IF/ID becomes a bubble even if `stall_d` = 1;
  - the skid buffer is cleared;
  - no request is issued in that cycle;
  - state transitions:
    - `F_IDLE` stays in `F_IDLE`;
    - `F_HOLD` goes to `F_IDLE`;
    - `F_WAIT` with `imem_rvalid` in the same cycle drops the response and goes to `F_IDLE`;
    - `F_WAIT` without `imem_rvalid` sets `discard` = 1 and stays in `F_WAIT`.
- **Redirect while `discard` = 1:** update `pc_f` only; `discard` stays 1.
- **PC arithmetic:** all PC arithmetic is modulo 2^32; 32'hFFFF_FFFC + 4 wraps to 0.

## Timing
- **Reset values:**
  - `pc_f` = `RESET_PC`, state `F_IDLE`, `discard` = 0, buffer empty;
  - `valid_d` = 0, `instr_d` = `NOP_INSTR`, `pc_d` = 0, `pc_plus4_d` = 4;
  - `imem_req` = 0 while `rst` = 1.
- **Reset mid-operation:** in-flight responses arriving after reset deasserts are never presented to IF/ID; reset forces `discard` = 1 if the state was `F_WAIT`.
- **First request:** asserted in the first cycle with `rst` = 0.
- **Throughput and latency:**
  - With 1-cycle memory and no stalls: one instruction per cycle.
  - Latency from `imem_rvalid` to `valid_d`: 1 cycle (registered).
- **Redirect penalty:** the request to `redirect_pc` is issued the cycle after `redirect_valid`; with 1-cycle memory the target reaches IF/ID 3 cycles after the redirect.
- **Combinational outputs:** `imem_req` and `imem_addr` are combinational from state, `pc_f`, `stall_f`, `redirect_valid`, `imem_rvalid` and `discard`. They have no path from `imem_rdata`.

## Configuration
- `FETCH_PERF_EN` defined:
  - adds outputs `perf_fetched` (32) and `perf_bubbles` (32);
  - `perf_fetched` counts cycles with an instruction loaded into IF/ID;
  - `perf_bubbles` counts cycles where IF/ID takes a bubble without `stall_d`;
  - both counters wrap, and both are reset to 0 by `rst`.
- Undefined: the ports and counters are absent; functional behaviour is identical.

## Structure
- Shared package `riscv_defines` gains:
  - `NOP_INSTR` (32'h0000_0013);
  - `fetch_state_t` enum {`F_IDLE`, `F_WAIT`, `F_HOLD`}.
- Sub-module `fetch_skid_buffer`: one-entry instr+PC register with `load`, `clear`, `valid`; instantiated once.
- The FSM, PC register and IF/ID register live in `fetch_unit`.

## Test plan
- Reset with `RESET_PC` = 32'h100 and 1-cycle memory, no stalls → `imem_addr` sequence 0x100, 0x104, 0x108; `valid_d` first goes high 2 cycles after reset release, with `pc_d` = 0x100.
- `stall_f` = `stall_d` = 1 for 2 cycles while a response arrives → word held in `F_HOLD`, `imem_req` = 0, IF/ID unchanged; after release the buffered word appears once and is never duplicated or lost.
- 3-cycle memory latency, redirect to 0x200 one cycle after a request to 0x10C → response for 0x10C discarded; next `imem_addr` = 0x200; `pc_d` never equals 0x10C.
- Redirect to 0x300 coincident with `stall_d` = 1 and a valid IF/ID entry → `valid_d` = 0 and `instr_d` = 32'h13 next cycle; first valid `pc_d` = 0x300.
- `pc_f` = 32'hFFFF_FFFC with continuous fetch → next `imem_addr` = 0; `pc_plus4_d` = 0 when `pc_d` = 32'hFFFF_FFFC.
- `rst` asserted while in `F_WAIT`, with the response arriving 1 cycle after release → response dropped; `valid_d` stays 0 until the fetch of `RESET_PC` completes.

Source files
------------

// File: rtl/riscv_defines_pkg.sv
// Shared definitions for the 5-stage RISC-V core: canonical NOP, fetch FSM
// state type, fetch buffer entry layout and small PC helpers.
package riscv_defines;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    F_IDLE = 2'd0,
    F_WAIT = 2'd1,
    F_HOLD = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

  // Sequential successor; wraps modulo 2^32.
  function automatic logic [31:0] pc_next(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

  // Instructions are word aligned; the low two bits of a target are ignored.
  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return pc & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/fetch_skid_buffer.sv
// One-entry instruction+PC holding register used by fetch_unit to park a
// returned word while decode is stalled. clear has priority over load.
module fetch_skid_buffer
  import riscv_defines::*;
(
  input  logic        clk,
  input  logic        load,
  input  logic        clear,
  input  logic [31:0] instr_in,
  input  logic [31:0] pc_in,
  output logic [31:0] instr_out,
  output logic [31:0] pc_out,
  output logic        valid
);

  fetch_entry_t entry_q, entry_d;
  logic         valid_q, valid_d;

  // Next-state for the entry and its valid flag.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned, which would otherwise infer a latch.
    entry_d = entry_q;
    valid_d = valid_q;
    if (clear) begin
      valid_d = 1'b0;
    end else if (load) begin
      entry_d = '{instr: instr_in, pc: pc_in};
      valid_d = 1'b1;
    end
  end

  // Entry register; clear is driven by the top-level reset as well.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    valid_q <= valid_d;
    // NOTE: the payload is deliberately not reset; valid_q qualifies it, so
    // resetting the data bits would only add reset fan-out.
    entry_q <= entry_d;
  end

  assign instr_out = entry_q.instr;
  assign pc_out    = entry_q.pc;
  assign valid     = valid_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC register, single-outstanding instruction memory
// request FSM, one-entry skid buffer and the IF/ID pipeline register.
// Optional build macro FETCH_PERF_EN adds perf_fetched / perf_bubbles
// counters; without it the counters and their ports do not exist.
module fetch_unit
  import riscv_defines::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_f,
  input  logic        stall_d,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr_d,
  output logic [31:0] pc_d,
  output logic [31:0] pc_plus4_d,
  output logic        valid_d
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_bubbles
`endif
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_f_q, pc_f_d;
  logic         discard_q, discard_d;

  logic [31:0]  instr_d_q, instr_d_d;
  logic [31:0]  pc_d_q, pc_d_d;
  logic         valid_d_q, valid_d_d;

  logic         req_c;
  logic [31:0]  addr_c;
  logic         deliver;
  logic [31:0]  deliver_instr;
  logic [31:0]  deliver_pc;
  logic         bubble;

  logic         buf_load;
  logic         buf_clear;
  logic         buf_valid;
  logic [31:0]  buf_instr;
  logic [31:0]  buf_pc;

  // A redirect or reset invalidates whatever word is parked.
  assign buf_clear = rst || redirect_valid;

  fetch_skid_buffer u_skid (
    .clk       (clk),
    .load      (buf_load),
    .clear     (buf_clear),
    .instr_in  (imem_rdata),
    .pc_in     (pc_f_q),
    .instr_out (buf_instr),
    .pc_out    (buf_pc),
    .valid     (buf_valid)
  );

  // Fetch FSM: request issue, response handling, PC advance and redirect.
  always_comb begin
    state_d       = state_q;
    pc_f_d        = pc_f_q;
    discard_d     = discard_q;
    req_c         = 1'b0;
    addr_c        = pc_f_q;
    deliver       = 1'b0;
    deliver_instr = imem_rdata;
    deliver_pc    = pc_f_q;
    buf_load      = 1'b0;

    if (redirect_valid) begin
      // Redirect wins over both stalls and never issues a request itself.
      pc_f_d  = align_pc(redirect_pc);
      state_d = F_IDLE;
      if (state_q == F_WAIT) begin
        if (imem_rvalid) begin
          discard_d = 1'b0;
        end else begin
          // The in-flight word belongs to the old path; drop it on arrival.
          state_d   = F_WAIT;
          discard_d = 1'b1;
        end
      end
    end else begin
      case (state_q)
        F_IDLE: begin
          req_c = !stall_f;
          if (!stall_f) state_d = F_WAIT;
        end
        F_WAIT: begin
          if (imem_rvalid) begin
            if (discard_q) begin
              discard_d = 1'b0;
              state_d   = F_IDLE;
            end else if (!stall_d) begin
              deliver = 1'b1;
              pc_f_d  = pc_next(pc_f_q);
              if (!stall_f) begin
                // Back-to-back issue keeps one instruction per cycle.
                req_c  = 1'b1;
                addr_c = pc_next(pc_f_q);
              end else begin
                state_d = F_IDLE;
              end
            end else begin
              buf_load = 1'b1;
              state_d  = F_HOLD;
            end
          end
        end
        F_HOLD: begin
          if (!stall_d) begin
            state_d = F_IDLE;
            if (buf_valid) begin
              deliver       = 1'b1;
              deliver_instr = buf_instr;
              deliver_pc    = buf_pc;
              pc_f_d        = pc_next(pc_f_q);
            end
          end
        end
        default: state_d = F_IDLE;
      endcase
    end
  end

  // IF/ID next value: load, bubble or hold.
  always_comb begin
    instr_d_d = instr_d_q;
    pc_d_d    = pc_d_q;
    valid_d_d = valid_d_q;
    bubble    = 1'b0;
    if (redirect_valid) begin
      bubble = 1'b1;
    end else if (deliver) begin
      instr_d_d = deliver_instr;
      pc_d_d    = deliver_pc;
      valid_d_d = 1'b1;
    end else if (!stall_d) begin
      bubble = 1'b1;
    end
    if (bubble) begin
      instr_d_d = NOP_INSTR;
      valid_d_d = 1'b0;
    end
  end

  // State, PC and IF/ID registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      // A request issued before reset may still answer after it; stay in
      // F_WAIT with discard set so that answer is dropped, not decoded.
      if (state_q == F_WAIT && !imem_rvalid) begin
        state_q   <= F_WAIT;
        discard_q <= 1'b1;
      end else begin
        state_q   <= F_IDLE;
        discard_q <= 1'b0;
      end
      pc_f_q    <= RESET_PC;
      instr_d_q <= NOP_INSTR;
      pc_d_q    <= '0;
      valid_d_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      discard_q <= discard_d;
      pc_f_q    <= pc_f_d;
      instr_d_q <= instr_d_d;
      pc_d_q    <= pc_d_d;
      valid_d_q <= valid_d_d;
    end
  end

  assign imem_req   = req_c && !rst;
  assign imem_addr  = addr_c;
  assign instr_d    = instr_d_q;
  assign pc_d       = pc_d_q;
  assign pc_plus4_d = pc_next(pc_d_q);
  assign valid_d    = valid_d_q;

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched_q, perf_fetched_d;
  logic [31:0] perf_bubbles_q, perf_bubbles_d;

  // Free-running wrap-around event counters.
  always_comb begin
    perf_fetched_d = perf_fetched_q + {31'd0, deliver};
    perf_bubbles_d = perf_bubbles_q + {31'd0, bubble && !stall_d};
  end

  // Counter registers, cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetched_q <= '0;
      perf_bubbles_q <= '0;
    end else begin
      perf_fetched_q <= perf_fetched_d;
      perf_bubbles_q <= perf_bubbles_d;
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_bubbles = perf_bubbles_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios followed by a
// randomized run, checked against an instruction-stream reference model and
// a single-outstanding variable-latency memory model.
module tb_fetch_unit;
  import riscv_defines::*;

  localparam logic [31:0] RST_PC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall_f = 1'b0;
  logic        stall_d = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] instr_d;
  logic [31:0] pc_d;
  logic [31:0] pc_plus4_d;
  logic        valid_d;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_bubbles;
`endif

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(RST_PC)) dut (
    .clk            (clk),
    .rst            (rst),
    .stall_f        (stall_f),
    .stall_d        (stall_d),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .instr_d        (instr_d),
    .pc_d           (pc_d),
    .pc_plus4_d     (pc_plus4_d),
    .valid_d        (valid_d)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched   (perf_fetched),
    .perf_bubbles   (perf_bubbles)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Instruction memory contents as a pure function of the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
  endfunction

  // Memory model state.
  bit          mem_pend = 1'b0;
  logic [31:0] mem_addr_q = '0;
  int          mem_cnt = 0;
  int          mem_lat_cfg = 1;
  bit          mem_rand_lat = 1'b0;

  // Inputs applied on the next cycle.
  bit          drv_rst = 1'b1;
  bit          drv_sf = 1'b0;
  bit          drv_sd = 1'b0;
  bit          drv_redir = 1'b0;
  logic [31:0] drv_rpc = '0;

  // Reference model: next expected PC in program order and last IF/ID view.
  logic [31:0] exp_pc = RST_PC;
  bit          prev_rst = 1'b1;
  bit          prev_sd = 1'b0;
  bit          prev_redir = 1'b0;
  logic [31:0] last_instr = '0;
  logic [31:0] last_pc = '0;
  logic        last_valid = 1'b0;
  int          n_deliv = 0;

  // Samples of the current cycle.
  logic        obs_req;
  logic [31:0] obs_addr;
  logic        obs_valid;
  logic [31:0] obs_instr;
  logic [31:0] obs_pcd;
  logic [31:0] obs_p4;

  // Advance one clock: apply inputs, sample mid-cycle, run the models.
  task automatic run_cycle();
    @(posedge clk);
    #1;
    imem_rvalid = 1'b0;
    imem_rdata  = $urandom;
    if (mem_pend) begin
      mem_cnt--;
      if (mem_cnt == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mem_word(mem_addr_q);
        mem_pend    = 1'b0;
      end
    end
    rst            = drv_rst;
    stall_f        = drv_sf;
    stall_d        = drv_sd;
    redirect_valid = drv_redir;
    redirect_pc    = drv_rpc;
    @(negedge clk);
    obs_req   = imem_req;
    obs_addr  = imem_addr;
    obs_valid = valid_d;
    obs_instr = instr_d;
    obs_pcd   = pc_d;
    obs_p4    = pc_plus4_d;

    if (prev_rst) begin
      check("rst_valid", obs_valid, 1'b0);
      check("rst_instr", obs_instr, NOP_INSTR);
      check("rst_pcd", obs_pcd, 32'h0);
    end else if (prev_redir) begin
      check("redir_valid", obs_valid, 1'b0);
      check("redir_instr", obs_instr, NOP_INSTR);
      check("redir_pcd_hold", obs_pcd, last_pc);
    end else if (prev_sd) begin
      check("stall_valid_hold", obs_valid, last_valid);
      check("stall_instr_hold", obs_instr, last_instr);
      check("stall_pcd_hold", obs_pcd, last_pc);
    end else if (obs_valid) begin
      check("stream_pc", obs_pcd, exp_pc);
      check("stream_instr", obs_instr, mem_word(exp_pc));
      exp_pc = exp_pc + 32'd4;
      n_deliv++;
    end else begin
      check("bubble_instr", obs_instr, NOP_INSTR);
      check("bubble_pcd_hold", obs_pcd, last_pc);
    end
    check("pc_plus4", obs_p4, obs_pcd + 32'd4);

    if (drv_rst) check("req_in_rst", obs_req, 1'b0);
    if (obs_req) begin
      check("one_outstanding", mem_pend, 1'b0);
      check("addr_aligned", obs_addr & 32'h3, 32'h0);
      mem_pend   = 1'b1;
      mem_addr_q = obs_addr;
      mem_cnt    = mem_rand_lat ? int'($urandom_range(1, 3)) : mem_lat_cfg;
    end

    if (drv_rst) exp_pc = RST_PC;
    else if (drv_redir) exp_pc = drv_rpc & 32'hFFFF_FFFC;
    prev_rst   = drv_rst;
    prev_sd    = drv_sd;
    prev_redir = drv_redir;
    last_instr = obs_instr;
    last_pc    = obs_pcd;
    last_valid = obs_valid;
  endtask

  logic [31:0] wrap_exp [3];

  initial begin
    bit found;
    bit seen_wrap;
    int idx;
    int deliv_start;

    // Reset, then stream from RESET_PC with 1-cycle memory.
    drv_rst = 1'b1;
    run_cycle();
    run_cycle();
    check("rst_req_0", obs_req, 1'b0);
    drv_rst = 1'b0;
    run_cycle();
    check("first_req", obs_req, 1'b1);
    check("first_addr", obs_addr, 32'h100);
    check("first_valid", obs_valid, 1'b0);
    run_cycle();
    check("addr_104", obs_addr, 32'h104);
    check("valid_c1", obs_valid, 1'b0);
    run_cycle();
    check("addr_108", obs_addr, 32'h108);
    check("valid_c2", obs_valid, 1'b1);
    check("pcd_c2", obs_pcd, 32'h100);

    // Both stalls for two cycles while the 0x108 word returns.
    drv_sf = 1'b1;
    drv_sd = 1'b1;
    run_cycle();
    check("hold_req_a", obs_req, 1'b0);
    check("hold_pcd_a", obs_pcd, 32'h104);
    run_cycle();
    check("hold_req_b", obs_req, 1'b0);
    check("hold_pcd_b", obs_pcd, 32'h104);
    drv_sf = 1'b0;
    drv_sd = 1'b0;
    run_cycle();
    check("unhold_req", obs_req, 1'b0);
    check("unhold_pcd", obs_pcd, 32'h104);
    mem_lat_cfg = 3;
    run_cycle();
    check("skid_out_pcd", obs_pcd, 32'h108);
    check("skid_out_valid", obs_valid, 1'b1);
    check("req_10c", obs_req, 1'b1);
    check("addr_10c", obs_addr, 32'h10C);

    // Redirect to 0x200 while 0x10C is still in flight (3-cycle memory).
    drv_redir = 1'b1;
    drv_rpc   = 32'h200;
    run_cycle();
    check("redir_no_req", obs_req, 1'b0);
    drv_redir = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 8 && !found; i++) begin
      run_cycle();
      if (obs_req) begin
        found = 1'b1;
        check("redir_addr_200", obs_addr, 32'h200);
      end
    end
    check("redir_req_seen", found, 1'b1);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      run_cycle();
      if (obs_valid) begin
        found = 1'b1;
        check("first_pcd_200", obs_pcd, 32'h200);
      end
    end
    check("valid_200_seen", found, 1'b1);

    // Redirect to 0x300 with stall_d over a valid IF/ID entry.
    mem_lat_cfg = 1;
    found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      run_cycle();
      if (obs_valid) found = 1'b1;
    end
    check("stream_resumed", found, 1'b1);
    drv_redir = 1'b1;
    drv_sd    = 1'b1;
    drv_rpc   = 32'h300;
    run_cycle();
    check("pre_redir_valid", obs_valid, 1'b1);
    drv_redir = 1'b0;
    drv_sd    = 1'b0;
    run_cycle();
    check("r300_valid0", obs_valid, 1'b0);
    check("r300_nop", obs_instr, 32'h13);
    check("r300_req", obs_req, 1'b1);
    check("r300_addr", obs_addr, 32'h300);
    run_cycle();
    check("r300_valid_r2", obs_valid, 1'b0);
    run_cycle();
    check("r300_valid_r3", obs_valid, 1'b1);
    check("r300_pcd", obs_pcd, 32'h300);

    // PC wrap at the top of the address space.
    wrap_exp[0] = 32'hFFFF_FFF8;
    wrap_exp[1] = 32'hFFFF_FFFC;
    wrap_exp[2] = 32'h0000_0000;
    drv_redir = 1'b1;
    drv_rpc   = 32'hFFFF_FFF8;
    run_cycle();
    drv_redir = 1'b0;
    idx = 0;
    seen_wrap = 1'b0;
    for (int i = 0; i < 12; i++) begin
      run_cycle();
      if (obs_req && idx < 3) begin
        check("wrap_addr", obs_addr, wrap_exp[idx]);
        idx++;
      end
      if (obs_valid && obs_pcd == 32'hFFFF_FFFC) begin
        seen_wrap = 1'b1;
        check("wrap_plus4", obs_p4, 32'h0);
      end
    end
    check("wrap_done", {30'd0, idx == 3, seen_wrap}, 32'h3);

    // Reset while a request is outstanding; answer arrives after release.
    mem_lat_cfg = 3;
    drv_redir = 1'b1;
    drv_rpc   = 32'h400;
    run_cycle();
    drv_redir = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      run_cycle();
      if (obs_req) found = 1'b1;
    end
    check("pre_rst_req", found, 1'b1);
    drv_rst = 1'b1;
    run_cycle();
    drv_rst = 1'b0;
    run_cycle();
    check("post_rst_wait_req", obs_req, 1'b0);
    run_cycle();
    check("stale_resp_req", obs_req, 1'b0);
    check("stale_resp_valid", obs_valid, 1'b0);
    found = 1'b0;
    idx = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      run_cycle();
      if (obs_req && idx == 0) begin
        idx = 1;
        check("post_rst_addr", obs_addr, RST_PC);
      end
      if (obs_valid) begin
        found = 1'b1;
        check("post_rst_pcd", obs_pcd, RST_PC);
      end
    end
    check("post_rst_valid_seen", found, 1'b1);

    // Randomized stalls, redirects, latencies and occasional resets.
    mem_rand_lat = 1'b1;
    deliv_start = n_deliv;
    for (int i = 0; i < 1500; i++) begin
      drv_sf    = ($urandom % 4) == 0;
      drv_sd    = ($urandom % 4) == 0;
      drv_redir = ($urandom % 20) == 0;
      drv_rpc   = $urandom;
      drv_rst   = ($urandom % 250) == 0;
      run_cycle();
    end
    drv_sf    = 1'b0;
    drv_sd    = 1'b0;
    drv_redir = 1'b0;
    drv_rst   = 1'b0;
    for (int i = 0; i < 8; i++) run_cycle();
    check("random_progress", n_deliv - deliv_start > 100, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
